// File: rtl/wb_trace_checker.sv
// wb_trace_checker: compares retiring write-back commits against a FIFO of golden trace entries
module wb_trace_checker #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] debug_wb_pc,
    input  logic [3:0]  debug_wb_rf_we,
    input  logic [4:0]  debug_wb_rf_wnum,
    input  logic [31:0] debug_wb_rf_wdata,
    input  logic        gold_valid,
    output logic        gold_ready,
    input  logic [31:0] gold_pc,
    input  logic [4:0]  gold_wnum,
    input  logic [31:0] gold_wdata,
    output logic [1:0]  state,
    output logic        err,
    output logic [31:0] err_pc,
    output logic [31:0] err_got_wdata,
    output logic [31:0] err_exp_wdata,
    output logic [31:0] pass_cnt,
    output logic [4:0]  fifo_cnt
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, ERROR = 2'b10, UNDERRUN = 2'b11} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } entry_t;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    entry_t mem_q [DEPTH];
    state_t state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0] cnt_q, cnt_d;
    logic [31:0] pass_q, pass_d, err_pc_q, err_pc_d, err_got_q, err_got_d, err_exp_q, err_exp_d;
    logic commit, push, empty, bypass, pop, store, match;
    logic [31:0] lane_mask;
    entry_t exp_e;
    assign state = state_q;
    assign err = state_q[1];
    assign err_pc = err_pc_q;
    assign err_got_wdata = err_got_q;
    assign err_exp_wdata = err_exp_q;
    assign pass_cnt = pass_q;
    assign fifo_cnt = cnt_q;
    // handshake, pop/bypass decision, lane-masked compare and next-state
    always_comb begin
        commit = (debug_wb_rf_we != 4'b0) && (debug_wb_rf_wnum != 5'd0);
        gold_ready = (cnt_q < 5'(DEPTH)) && !state_q[1];
        push = gold_valid && gold_ready;
        empty = cnt_q == 5'd0;
        bypass = (state_q == RUN) && commit && empty && push;
        pop = (state_q == RUN) && commit && !empty;
        store = push && !bypass;
        exp_e = bypass ? {gold_pc, gold_wnum, gold_wdata} : mem_q[rd_ptr_q];
        lane_mask = {{8{debug_wb_rf_we[3]}}, {8{debug_wb_rf_we[2]}}, {8{debug_wb_rf_we[1]}}, {8{debug_wb_rf_we[0]}}};
        match = (debug_wb_pc == exp_e.pc) && (debug_wb_rf_wnum == exp_e.wnum) &&
                (((debug_wb_rf_wdata ^ exp_e.wdata) & lane_mask) == 32'd0);
        state_d = state_q;
        pass_d = pass_q;
        err_pc_d = err_pc_q;
        err_got_d = err_got_q;
        err_exp_d = err_exp_q;
        if (state_q == IDLE && push)
            state_d = RUN;
        if (state_q == RUN && commit) begin
            if (empty && !push) begin
                state_d = UNDERRUN;
                err_pc_d = debug_wb_pc;
                err_got_d = debug_wb_rf_wdata;
                err_exp_d = 32'd0;
            end else if (match) begin
                pass_d = pass_q + {31'd0, pass_q != 32'hFFFF_FFFF};
            end else begin
                state_d = ERROR;
                err_pc_d = debug_wb_pc;
                err_got_d = debug_wb_rf_wdata;
                err_exp_d = exp_e.wdata;
            end
        end
        wr_ptr_d = store ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d = cnt_q + {4'd0, store} - {4'd0, pop};
    end
    // control and capture registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q <= '0;
            pass_q <= '0;
            err_pc_q <= '0;
            err_got_q <= '0;
            err_exp_q <= '0;
        end else begin
            state_q <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q <= cnt_d;
            pass_q <= pass_d;
            err_pc_q <= err_pc_d;
            err_got_q <= err_got_d;
            err_exp_q <= err_exp_d;
        end
    end
    // golden entry storage, unreset; bypassed entries are never written
    always_ff @(posedge clk) begin
        if (store && !reset)
            mem_q[wr_ptr_q] <= {gold_pc, gold_wnum, gold_wdata};
    end
endmodule

// File: tb/tb_wb_trace_checker.sv
// tb_wb_trace_checker: table-driven scoreboard bench for wb_trace_checker
module tb_wb_trace_checker;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        gold_valid;
    logic        gold_ready;
    logic [31:0] gold_pc;
    logic [4:0]  gold_wnum;
    logic [31:0] gold_wdata;
    logic [1:0]  state;
    logic        err;
    logic [31:0] err_pc, err_got_wdata, err_exp_wdata, pass_cnt;
    logic [4:0]  fifo_cnt;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] ps;
        logic [4:0]  fc;
        logic        rdy;
        logic [31:0] epc, eg, ee;
    } exp_t;
    typedef struct {
        logic        r, gv;
        logic [31:0] gpc;
        logic [4:0]  gwn;
        logic [31:0] gwd;
        logic [3:0]  we;
        logic [4:0]  wn;
        logic [31:0] pc, wd;
        exp_t        e;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int n_vec = 0;
    int n_bad = 0;
    localparam logic [31:0] B = 32'h1c00_0000;

    wb_trace_checker #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .gold_valid(gold_valid), .gold_ready(gold_ready),
        .gold_pc(gold_pc), .gold_wnum(gold_wnum), .gold_wdata(gold_wdata),
        .state(state), .err(err), .err_pc(err_pc), .err_got_wdata(err_got_wdata),
        .err_exp_wdata(err_exp_wdata), .pass_cnt(pass_cnt), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(logic r, logic gv, logic [31:0] gpc, logic [4:0] gwn, logic [31:0] gwd,
                               logic [3:0] we, logic [4:0] wn, logic [31:0] pc, logic [31:0] wd,
                               logic [1:0] st, logic [31:0] ps, logic [4:0] fc, logic rdy,
                               logic [31:0] epc, logic [31:0] eg, logic [31:0] ee);
        vec_t t;
        t.r = r; t.gv = gv; t.gpc = gpc; t.gwn = gwn; t.gwd = gwd;
        t.we = we; t.wn = wn; t.pc = pc; t.wd = wd;
        t.e.st = st; t.e.ps = ps; t.e.fc = fc; t.e.rdy = rdy;
        t.e.epc = epc; t.e.eg = eg; t.e.ee = ee;
        return t;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h, want %h", nm, n_vec, got, want);
        end
    endtask

    task automatic check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard vec %0d: got empty queue, want an entry", n_vec);
            return;
        end
        e = sb_q.pop_front();
        cmp("state", 32'(state), 32'(e.st));
        cmp("err", 32'(err), 32'(e.st[1]));
        cmp("pass_cnt", pass_cnt, e.ps);
        cmp("fifo_cnt", 32'(fifo_cnt), 32'(e.fc));
        cmp("gold_ready", 32'(gold_ready), 32'(e.rdy));
        cmp("err_pc", err_pc, e.epc);
        cmp("err_got_wdata", err_got_wdata, e.eg);
        cmp("err_exp_wdata", err_exp_wdata, e.ee);
    endtask

    task automatic apply(input vec_t t);
        reset = t.r; gold_valid = t.gv; gold_pc = t.gpc; gold_wnum = t.gwn; gold_wdata = t.gwd;
        debug_wb_rf_we = t.we; debug_wb_rf_wnum = t.wn; debug_wb_pc = t.pc; debug_wb_rf_wdata = t.wd;
        sb_q.push_back(t.e);
        @(posedge clk);
        #1;
        n_vec++;
        check();
    endtask

    initial begin
        reset = 1'b1; gold_valid = 1'b0; gold_pc = '0; gold_wnum = '0; gold_wdata = '0;
        debug_wb_rf_we = '0; debug_wb_rf_wnum = '0; debug_wb_pc = '0; debug_wb_rf_wdata = '0;
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, B, 1, 32'h11, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, B + 4, 2, 32'h22, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, B + 8, 3, 32'h33, 0, 0, 0, 0, 1, 0, 3, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 4'hF, 1, B, 32'h11, 1, 1, 2, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 4'hF, 2, B + 4, 32'h22, 1, 2, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 4'hF, 3, B + 8, 32'h33, 1, 3, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, B + 12, 5, 32'h55, 4'hF, 5, B + 12, 32'h55, 1, 4, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, B + 16, 6, 32'h66, 0, 0, 0, 0, 1, 4, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, B + 20, 7, 32'h77, 0, 0, 0, 0, 1, 4, 2, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 4'hF, 0, B + 16, 32'h66, 1, 4, 2, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 4'h0, 6, B + 16, 32'h66, 1, 4, 2, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 4'hF, 6, B + 16, 32'h66, 1, 5, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 4'hF, 7, B + 20, 32'h77, 1, 6, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, B, 4, 32'hAABBCCDD, 0, 0, 0, 0, 1, 6, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 4'hE, 4, B, 32'hAABBCC00, 1, 7, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, B, 4, 32'hAABBCCDD, 0, 0, 0, 0, 1, 7, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 4'hF, 4, B, 32'hAABBCC00, 2, 7, 0, 0, B, 32'hAABBCC00, 32'hAABBCCDD));
        tbl.push_back(v(0, 1, 32'h200, 1, 1, 4'hF, 1, 32'h200, 1, 2, 7, 0, 0, B, 32'hAABBCC00, 32'hAABBCCDD));
        tbl.push_back(v(1, 1, 32'h200, 1, 1, 4'hF, 1, 32'h200, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 4'hF, 1, 32'h300, 3, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 32'h100, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 4'hF, 1, 32'h100, 1, 1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 4'hF, 2, 32'h104, 2, 3, 1, 0, 0, 32'h104, 2, 0));
        tbl.push_back(v(0, 1, 32'h108, 3, 3, 4'hF, 3, 32'h108, 3, 3, 1, 0, 0, 32'h104, 2, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 32'h600, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(1, 1, 32'h604, 2, 2, 4'hF, 1, 32'h600, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 4'hF, 1, 32'h600, 1, 0, 0, 0, 1, 0, 0, 0));
        foreach (tbl[k]) apply(tbl[k]);
        for (int i = 0; i < 8; i++)
            apply(v(0, 1, 32'h400 + 32'(4 * i), 5'(i + 1), 32'(i), 0, 0, 0, 0, 1, 0, 5'(i + 1), i < 7, 0, 0, 0));
        apply(v(0, 1, 32'h500, 9, 9, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, 0));
        apply(v(0, 1, 32'h500, 9, 9, 4'hF, 1, 32'h400, 0, 1, 1, 7, 1, 0, 0, 0));
        apply(v(0, 0, 0, 0, 0, 4'hF, 2, 32'h404, 1, 1, 2, 6, 1, 0, 0, 0));
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: got %0d left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_trace_checker.md
WB_TRACE_CHECKER -- requirements
Module: wb_trace_checker

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the golden-entry FIFO depth (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port debug_wb_pc, input, 32 bits: PC of the retiring instruction.
REQ-005 The block SHALL have port debug_wb_rf_we, input, 4 bits: byte write enables of the retiring instruction.
REQ-006 The block SHALL have port debug_wb_rf_wnum, input, 5 bits: destination register number.
REQ-007 The block SHALL have port debug_wb_rf_wdata, input, 32 bits: write-back data.
REQ-008 The block SHALL have port gold_valid, input, 1 bit: a golden entry is offered.
REQ-009 The block SHALL have port gold_ready, output, 1 bit: the block can accept a golden entry.
REQ-010 The block SHALL have ports gold_pc (input, 32 bits), gold_wnum (input, 5 bits) and gold_wdata (input, 32 bits): the expected trace entry.
REQ-011 The block SHALL have port state, output, 2 bits: IDLE=00, RUN=01, ERROR=10, UNDERRUN=11.
REQ-012 The block SHALL have port err, output, 1 bit: sticky; high exactly when state is ERROR or UNDERRUN.
REQ-013 The block SHALL have ports err_pc, err_got_wdata and err_exp_wdata, outputs, 32 bits each: capture of the first failing commit.
REQ-014 The block SHALL have port pass_cnt, output, 32 bits: number of matched commits.
REQ-015 The block SHALL have port fifo_cnt, output, 5 bits: current golden FIFO occupancy.

Function
REQ-016 A commit event SHALL be defined as debug_wb_rf_we != 0 and debug_wb_rf_wnum != 0; all other cycles are ignored.
REQ-017 A push SHALL occur on a rising edge where gold_valid && gold_ready; gold_ready = (fifo_cnt < DEPTH) && state in {IDLE, RUN}, derived from registered state only, so a full FIFO takes no push even in a pop cycle.
REQ-018 The FIFO SHALL be circular with read and write pointers modulo DEPTH; a simultaneous push and pop in one cycle SHALL leave fifo_cnt unchanged.
REQ-019 In IDLE, commits SHALL be ignored; the first push SHALL move the state to RUN.
REQ-020 In RUN, each commit SHALL pop one entry and compare it in the same cycle.
REQ-021 A match SHALL require debug_wb_pc == gold_pc, debug_wb_rf_wnum == gold_wnum, and equality of wdata on every byte lane whose we bit is 1; disabled lanes are not compared.
REQ-022 If a commit arrives in RUN with fifo_cnt == 0 and a push in the same cycle, the commit SHALL be compared directly against the pushed entry (bypass), and the entry SHALL NOT be stored.
REQ-023 A commit in RUN with fifo_cnt == 0 and no same-cycle push SHALL move the state to UNDERRUN, capturing err_pc and err_got_wdata, with err_exp_wdata = 0.
REQ-024 A mismatch SHALL move the state to ERROR on the next edge, capturing debug_wb_pc, debug_wb_rf_wdata and the expected gold_wdata.
REQ-025 pass_cnt SHALL increment on the edge after a matched commit and saturate at 32'hFFFF_FFFF.
REQ-026 ERROR and UNDERRUN SHALL be terminal until reset: no pushes, no pops, and pass_cnt, the err_* captures and fifo_cnt frozen.
REQ-027 err_* outputs SHALL capture only on the transition into ERROR or UNDERRUN, never overwritten afterwards.

Reset
REQ-028 While reset is high at a rising edge, the block SHALL set state = IDLE, err = 0, pass_cnt = 0, fifo_cnt = 0, both pointers = 0, and err_pc, err_got_wdata, err_exp_wdata = 0.
REQ-029 FIFO storage SHALL need no reset; gold_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-030 Reset asserted mid-operation, in any state, SHALL discard all FIFO contents and take effect on that edge regardless of same-cycle commits or pushes.

Verification
REQ-031 Push 3 entries (pc 0x1c000000/04/08, wnum 1/2/3, wdata 0x11/0x22/0x33), then 3 matching commits -> state RUN, pass_cnt = 3, fifo_cnt = 0, err = 0.
REQ-032 Push entry (0x1c000000, r4, 0xAABBCCDD); commit with wdata 0xAABBCC00 and we = 4'b1110 -> match, pass_cnt = 1; the same commit with we = 4'b1111 -> ERROR, err_got_wdata = 0xAABBCC00, err_exp_wdata = 0xAABBCCDD.
REQ-033 After one push, retire 2 commits -> second commit gives UNDERRUN, err_pc = the second PC, pass_cnt = 1, gold_ready = 0.
REQ-034 Hold gold_valid with DEPTH = 8 and no commits -> fifo_cnt reaches 8, gold_ready = 0; one commit -> fifo_cnt = 7 on the next edge, gold_ready = 1.
REQ-035 Empty FIFO in RUN, push and commit in the same cycle with equal contents -> pass_cnt + 1, fifo_cnt stays 0, no UNDERRUN.
REQ-036 A commit with wnum = 0, or with we = 0, while the FIFO holds 2 entries -> no pop, fifo_cnt = 2; assert reset in ERROR -> IDLE, all counters 0.
